// File: rtl/zxw_sweep_reader.sv
// Sweeps SW_out across 0..NUM_ADDR-1, dwells DWELL cycles per address, then offers Display_in as a valid/ready sample.
// Optional ZXW_SWEEP_CHECKSUM_EN adds a 16-bit running sum of accepted sample data on port Checksum.
module zxw_sweep_reader #(
    parameter int DWELL    = 150,
    parameter int NUM_ADDR = 32
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Start,
    input  logic       Abort,
    output logic [4:0] SW_out,
    input  logic [7:0] Display_in,
    output logic [7:0] Sample_data,
    output logic [4:0] Sample_addr,
    output logic       Sample_valid,
    input  logic       Sample_ready,
    output logic       Busy,
`ifdef ZXW_SWEEP_CHECKSUM_EN
    output logic       Done,
    output logic [15:0] Checksum
`else
    output logic       Done
`endif
);

    // state   | meaning
    // S_IDLE  | waiting for Start
    // S_DWELL | SW_out settling, counting DWELL cycles
    // S_HOLD  | sample presented, waiting for Sample_ready
    // S_DONE  | one-cycle Done pulse after last transfer
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] LAST_CNT  = 16'(DWELL - 1);
    localparam logic [4:0]  LAST_ADDR = 5'(NUM_ADDR - 1);

    state_t      state, next_state;
    logic [15:0] dwell_cnt;
    logic        start_go;
    logic        abort_go;
    logic        count_inc;
    logic        capture;
    logic        xfer;
    logic        last_addr;

    assign last_addr = (SW_out == LAST_ADDR);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start_go   = 1'b0;
        abort_go   = 1'b0;
        count_inc  = 1'b0;
        capture    = 1'b0;
        xfer       = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    start_go   = 1'b1;
                    next_state = S_DWELL;
                end
            end
            S_DWELL: begin
                if (Abort) begin
                    abort_go   = 1'b1;
                    next_state = S_IDLE;
                end else if (dwell_cnt == LAST_CNT) begin
                    capture    = 1'b1;
                    next_state = S_HOLD;
                end else begin
                    count_inc  = 1'b1;
                end
            end
            S_HOLD: begin
                // Abort wins over a coincident handshake; the sample is dropped
                if (Abort) begin
                    abort_go   = 1'b1;
                    next_state = S_IDLE;
                end else if (Sample_valid && Sample_ready) begin
                    xfer       = 1'b1;
                    next_state = last_addr ? S_DONE : S_DWELL;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    assign Busy = (state != S_IDLE);
    assign Done = (state == S_DONE);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            SW_out       <= 5'd0;
            Sample_data  <= 8'd0;
            Sample_addr  <= 5'd0;
            Sample_valid <= 1'b0;
            dwell_cnt    <= 16'd0;
        end else begin
            if (start_go) begin
                SW_out    <= 5'd0;
                dwell_cnt <= 16'd0;
            end
            if (abort_go) begin
                SW_out       <= 5'd0;
                Sample_valid <= 1'b0;
            end
            if (count_inc) begin
                dwell_cnt <= dwell_cnt + 16'd1;
            end
            if (capture) begin
                Sample_data  <= Display_in;
                Sample_addr  <= SW_out;
                Sample_valid <= 1'b1;
            end
            if (xfer) begin
                Sample_valid <= 1'b0;
                if (!last_addr) begin
                    SW_out    <= SW_out + 5'd1;
                    dwell_cnt <= 16'd0;
                end
            end
        end
    end

`ifdef ZXW_SWEEP_CHECKSUM_EN
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            Checksum <= 16'd0;
        end else if (start_go) begin
            Checksum <= 16'd0;
        end else if (xfer) begin
            Checksum <= Checksum + {8'h00, Sample_data};
        end
    end
`endif

endmodule

// File: tb/tb_zxw_sweep_reader.sv
// Scoreboard bench for zxw_sweep_reader (DWELL=4, NUM_ADDR=32); matrix modelled as Display_in = SW_out*3.
// Checksum checks are compiled only when ZXW_SWEEP_CHECKSUM_EN is defined.
module tb_zxw_sweep_reader;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Start;
    logic       Abort;
    logic [4:0] SW_out;
    logic [7:0] Display_in;
    logic [7:0] Sample_data;
    logic [4:0] Sample_addr;
    logic       Sample_valid;
    logic       Sample_ready;
    logic       Busy;
    logic       Done;
`ifdef ZXW_SWEEP_CHECKSUM_EN
    logic [15:0] Checksum;
`endif

    logic        disp_ff = 1'b0;
    logic [12:0] exp_q[$];
    logic [12:0] exp_e;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          done_cnt = 0;
    int          cyc;
    int          d0;

    zxw_sweep_reader #(.DWELL(4), .NUM_ADDR(32)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .Start       (Start),
        .Abort       (Abort),
        .SW_out      (SW_out),
        .Display_in  (Display_in),
        .Sample_data (Sample_data),
        .Sample_addr (Sample_addr),
        .Sample_valid(Sample_valid),
        .Sample_ready(Sample_ready),
        .Busy        (Busy),
`ifdef ZXW_SWEEP_CHECKSUM_EN
        .Done        (Done),
        .Checksum    (Checksum)
`else
        .Done        (Done)
`endif
    );

    always #5 Clock = ~Clock;

    assign Display_in = disp_ff ? 8'hFF : 8'({3'b000, SW_out} * 8'd3);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_sweep(input int n, input bit ff);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = ff ? 8'hFF : 8'(3 * i);
            exp_q.push_back({5'(i), d});
        end
    endtask

    task automatic start_pulse();
        @(posedge Clock); #1 Start = 1'b1;
        @(posedge Clock); #1 Start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!Done && n < 600) begin
            @(posedge Clock); #1;
            n++;
        end
        chk("done_reached", {31'd0, Done}, 32'd1);
    endtask

    task automatic wait_addr(input logic [4:0] a, input logic v);
        int n;
        n = 0;
        while (!(SW_out == a && Sample_valid == v) && n < 600) begin
            @(posedge Clock); #1;
            n++;
        end
        chk("addr_reached", {26'd0, SW_out, Sample_valid}, {26'd0, a, v});
    endtask

    // Monitor: every accepted sample is matched against the scoreboard queue
    always @(negedge Clock) begin
        if (Resetn && Sample_valid && Sample_ready && !Abort) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_sample: addr %0d data %0h with empty queue", Sample_addr, Sample_data);
            end else begin
                exp_e = exp_q.pop_front();
                chk("sample_addr", {27'd0, Sample_addr}, {27'd0, exp_e[12:8]});
                chk("sample_data", {24'd0, Sample_data}, {24'd0, exp_e[7:0]});
            end
        end
        if (Done) done_cnt++;
    end

    initial begin
        Resetn = 1'b0; Start = 1'b0; Abort = 1'b0; Sample_ready = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        chk("reset_outputs", {12'd0, SW_out, Sample_data, Sample_addr, Sample_valid, Busy, Done},
            32'd0);
        Resetn = 1'b1;

        // Abort while idle is ignored
        @(posedge Clock); #1 Abort = 1'b1;
        @(posedge Clock); #1 Abort = 1'b0;
        chk("idle_abort_busy", {31'd0, Busy}, 32'd0);

        // Full sweep, ready tied high: Start-to-Done latency
        d0 = done_cnt;
        push_sweep(32, 1'b0);
        start_pulse();
        wait_done(cyc);
        chk("sweep_cycles", 32'(cyc), 32'd161);
        @(posedge Clock); #1;
        chk("done_one_cycle", {31'd0, Done}, 32'd0);
        chk("busy_after_done", {31'd0, Busy}, 32'd0);
        @(posedge Clock); #1;
        chk("done_count_a", 32'(done_cnt - d0), 32'd1);
        chk("queue_empty_a", 32'(exp_q.size()), 32'd0);
`ifdef ZXW_SWEEP_CHECKSUM_EN
        chk("checksum_3n", {16'd0, Checksum}, 32'h05D0);
`endif

        // Backpressure at addr 5
        d0 = done_cnt;
        push_sweep(32, 1'b0);
        start_pulse();
        wait_addr(5'd5, 1'b0);
        Sample_ready = 1'b0;
        wait_addr(5'd5, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_stable", {13'd0, Sample_valid, Sample_data, Sample_addr, SW_out},
                {13'd0, 1'b1, 8'd15, 5'd5, 5'd5});
            @(posedge Clock); #1;
        end
        Sample_ready = 1'b1;
        wait_done(cyc);
        @(posedge Clock); #1;
        chk("done_count_b", 32'(done_cnt - d0), 32'd1);
        chk("queue_empty_b", 32'(exp_q.size()), 32'd0);

        // Abort coincident with a handshake at addr 7
        d0 = done_cnt;
        push_sweep(7, 1'b0);
        start_pulse();
        wait_addr(5'd7, 1'b1);
        Abort = 1'b1;
        @(posedge Clock); #1 Abort = 1'b0;
        chk("abort_state", {25'd0, SW_out, Sample_valid, Busy}, 32'd0);
        repeat (5) @(posedge Clock);
        #1;
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("queue_empty_c", 32'(exp_q.size()), 32'd0);
        push_sweep(32, 1'b0);
        start_pulse();
        wait_done(cyc);
        chk("restart_cycles", 32'(cyc), 32'd161);
        @(posedge Clock); #1;
        chk("done_count_c", 32'(done_cnt - d0), 32'd1);

        // Start while busy at addr 10 is ignored
        d0 = done_cnt;
        push_sweep(32, 1'b0);
        start_pulse();
        wait_addr(5'd10, 1'b0);
        Start = 1'b1;
        @(posedge Clock); #1 Start = 1'b0;
        wait_done(cyc);
        repeat (4) @(posedge Clock);
        #1;
        chk("done_count_d", 32'(done_cnt - d0), 32'd1);
        chk("queue_empty_d", 32'(exp_q.size()), 32'd0);
        chk("busy_idle_d", {31'd0, Busy}, 32'd0);

        // Reset during DWELL at addr 20
        d0 = done_cnt;
        push_sweep(20, 1'b0);
        start_pulse();
        wait_addr(5'd20, 1'b0);
        Resetn = 1'b0;
        @(posedge Clock); #1;
        chk("midsweep_reset", {12'd0, SW_out, Sample_data, Sample_addr, Sample_valid, Busy, Done},
            32'd0);
        Resetn = 1'b1;
        repeat (20) @(posedge Clock);
        #1;
        chk("reset_no_done", 32'(done_cnt - d0), 32'd0);
        chk("queue_empty_e", 32'(exp_q.size()), 32'd0);
        chk("reset_stays_idle", {31'd0, Busy}, 32'd0);

`ifdef ZXW_SWEEP_CHECKSUM_EN
        disp_ff = 1'b1;
        push_sweep(32, 1'b1);
        start_pulse();
        wait_done(cyc);
        @(posedge Clock); #1;
        chk("checksum_ff", {16'd0, Checksum}, 32'h1FE0);
        disp_ff = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
